reset_sequencer: RTL and testbench

//   Takes the global logic reset and a set of reset requests. Releases NDOM

---
 rtl/reset_sequencer.sv | 168 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Releases NDOM downstream reset domains one at a time, in index order, waiting
// for each domain's ready flag plus a fixed gap; flags a sticky timeout on failure.
module reset_sequencer #(
    parameter int unsigned NDOM     = 4,
    parameter int unsigned NREQ     = 3,
    parameter int unsigned HOLD_MIN = 8,
    parameter int unsigned DELAY    = 16,
    parameter int unsigned TIMEOUT  = 1024,
    localparam int unsigned IDX_W   = (NDOM > 1) ? $clog2(NDOM) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NDOM-1:0]  domain_ready,
    output logic [NDOM-1:0]  domain_reset,
    output logic             all_ready,
    output logic             busy,
    output logic             timeout_err,
    output logic [IDX_W-1:0] fail_idx,
    output logic [NREQ-1:0]  cause
);

    localparam int unsigned CNT_MAX_HD = (HOLD_MIN > DELAY) ? HOLD_MIN : DELAY;
    localparam int unsigned CNT_MAX    = (CNT_MAX_HD > TIMEOUT) ? CNT_MAX_HD : TIMEOUT;
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_HOLD  = 3'd0,
        S_WAIT  = 3'd1,
        S_GAP   = 3'd2,
        S_RUN   = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [NDOM-1:0]  domain_reset_q, domain_reset_d;
    logic             all_ready_q, all_ready_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
    logic [NREQ-1:0]  cause_q, cause_d;

    logic             req_any;

    assign req_any = |req;

    // State and registered outputs; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_HOLD;
            cnt_q          <= '0;
            idx_q          <= '0;
            domain_reset_q <= '1;
            all_ready_q    <= 1'b0;
            busy_q         <= 1'b1;
            timeout_err_q  <= 1'b0;
            fail_idx_q     <= '0;
            cause_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            domain_reset_q <= domain_reset_d;
            all_ready_q    <= all_ready_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
            fail_idx_q     <= fail_idx_d;
            cause_q        <= cause_d;
        end
    end

    // Next state, shared counter and domain index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (req_any) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_MIN - 1)) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (domain_ready[idx_q]) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = S_FAULT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(DELAY - 1)) begin
                        cnt_d = '0;
                        if (idx_q == IDX_W'(NDOM - 1)) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_WAIT;
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output next values, derived from the current and next state
    always_comb begin
        domain_reset_d = domain_reset_q;
        timeout_err_d  = timeout_err_q;
        fail_idx_d     = fail_idx_q;
        cause_d        = cause_q;
        all_ready_d    = (state_d == S_RUN);
        busy_d         = (state_d == S_HOLD) || (state_d == S_WAIT) || (state_d == S_GAP);
        if (req_any) begin
            domain_reset_d = '1;
            // Requests accumulate only while already holding; a new hold starts fresh
            cause_d        = ((state_q == S_HOLD) ? cause_q : '0) | req;
            timeout_err_d  = 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (state_d == S_WAIT) begin
                        domain_reset_d[0] = 1'b0;
                    end
                end
                S_WAIT: begin
                    if (state_d == S_FAULT) begin
                        domain_reset_d[idx_q] = 1'b1;
                        timeout_err_d         = 1'b1;
                        fail_idx_d            = idx_q;
                    end
                end
                S_GAP: begin
                    if (state_d == S_WAIT) begin
                        domain_reset_d[idx_d] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign domain_reset = domain_reset_q;
    assign all_ready    = all_ready_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign fail_idx     = fail_idx_q;
    assign cause        = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized ready/req/reset
// traffic, checked every cycle against a behavioural model of the release sequence.
module tb_reset_sequencer;

    localparam int unsigned NDOM     = 2;
    localparam int unsigned NREQ     = 3;
    localparam int unsigned HOLD_MIN = 4;
    localparam int unsigned DELAY    = 2;
    localparam int unsigned TIMEOUT  = 8;
    localparam int unsigned IDX_W    = 1;

    localparam int M_HOLD  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_GAP   = 2;
    localparam int M_RUN   = 3;
    localparam int M_FAULT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req;
    logic [NDOM-1:0]  domain_ready;
    logic [NDOM-1:0]  domain_reset;
    logic             all_ready;
    logic             busy;
    logic             timeout_err;
    logic [IDX_W-1:0] fail_idx;
    logic [NREQ-1:0]  cause;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NDOM    (NDOM),
        .NREQ    (NREQ),
        .HOLD_MIN(HOLD_MIN),
        .DELAY   (DELAY),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .domain_ready(domain_ready),
        .domain_reset(domain_reset),
        .all_ready   (all_ready),
        .busy        (busy),
        .timeout_err (timeout_err),
        .fail_idx    (fail_idx),
        .cause       (cause)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase, cycles spent in it, current domain, and the sticky flags
    int              m_mode  = M_HOLD;
    int              m_el    = 0;
    int              m_dom   = 0;
    int              m_fail  = 0;
    bit              m_terr  = 1'b0;
    logic [NREQ-1:0] m_cause = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Domains 0..k-1 released means the low k bits are zero
    function automatic logic [31:0] released_low(input int k);
        int full;
        full = (1 << NDOM) - 1;
        return 32'(full & ~((1 << k) - 1));
    endfunction

    function automatic logic [31:0] exp_dreset();
        case (m_mode)
            M_WAIT, M_GAP: return released_low(m_dom + 1);
            M_RUN:         return 32'd0;
            M_FAULT:       return released_low(m_fail);
            default:       return released_low(0);
        endcase
    endfunction

    task automatic model_step();
        if (reset) begin
            m_mode = M_HOLD; m_el = 0; m_dom = 0;
            m_cause = '0; m_terr = 1'b0; m_fail = 0;
        end else if (req != '0) begin
            m_cause = ((m_mode == M_HOLD) ? m_cause : '0) | req;
            m_mode = M_HOLD; m_el = 0; m_dom = 0; m_terr = 1'b0;
        end else begin
            case (m_mode)
                M_HOLD: begin
                    m_el++;
                    if (m_el == int'(HOLD_MIN)) begin
                        m_mode = M_WAIT; m_el = 0; m_dom = 0;
                    end
                end
                M_WAIT: begin
                    if (domain_ready[m_dom]) begin
                        m_mode = M_GAP; m_el = 0;
                    end else begin
                        m_el++;
                        if (m_el == int'(TIMEOUT)) begin
                            m_mode = M_FAULT; m_fail = m_dom; m_terr = 1'b1;
                        end
                    end
                end
                M_GAP: begin
                    m_el++;
                    if (m_el == int'(DELAY)) begin
                        m_el = 0;
                        if (m_dom == int'(NDOM) - 1) m_mode = M_RUN;
                        else begin
                            m_dom++; m_mode = M_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock: update model on the edge, compare every output on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("domain_reset", 32'(domain_reset), exp_dreset());
        check("all_ready", 32'(all_ready), 32'(m_mode == M_RUN));
        check("busy", 32'(busy), 32'(m_mode == M_HOLD || m_mode == M_WAIT || m_mode == M_GAP));
        check("timeout_err", 32'(timeout_err), 32'(m_terr));
        check("fail_idx", 32'(fail_idx), 32'(m_fail));
        check("cause", 32'(cause), 32'(m_cause));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int req_left;
    logic [NREQ-1:0] req_val;
    int rmode;
    int k;

    initial begin
        reset = 1'b1;
        req = '0;
        domain_ready = 2'b11;
        req_left = 0;
        req_val = '0;

        // Reset state, then full release with ready tied high
        run(3);
        check("rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        run(14);
        check("s1_all_ready", 32'(all_ready), 32'd1);
        check("s1_dreset", 32'(domain_reset), 32'd0);

        // Request in RUN pulls every domain back and records its source
        req = 3'b010;
        cycle();
        check("s3_dreset", 32'(domain_reset), 32'h3);
        run(4);
        req = '0;
        check("s3_cause", 32'(cause), 32'h2);
        run(14);

        // Domain 0 never ready: timeout fault
        reset = 1'b1;
        domain_ready = 2'b10;
        cycle();
        reset = 1'b0;
        run(14);
        check("s2_terr", 32'(timeout_err), 32'd1);
        check("s2_fidx", 32'(fail_idx), 32'd0);
        check("s2_busy", 32'(busy), 32'd0);
        check("s2_dreset", 32'(domain_reset), 32'h3);

        // Requests on separate HOLD cycles accumulate
        req = 3'b001;
        cycle();
        req = 3'b000;
        cycle();
        req = 3'b100;
        cycle();
        req = '0;
        check("s4_cause", 32'(cause), 32'h5);
        check("s4_terr", 32'(timeout_err), 32'd0);

        // Request during GAP of domain 0
        domain_ready = 2'b11;
        k = 0;
        while (!(m_mode == M_GAP && m_dom == 0) && k < 20) begin
            cycle();
            k++;
        end
        check("s5_reach_gap", 32'(k < 20), 32'd1);
        req = 3'b001;
        cycle();
        req = '0;
        check("s5_dreset", 32'(domain_reset), 32'h3);

        // Reset while running
        run(15);
        check("s6_in_run", 32'(all_ready), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("s6_dreset", 32'(domain_reset), 32'h3);
        check("s6_cause", 32'(cause), 32'd0);

        // Randomized traffic in segments with differing ready behaviour
        for (int seg = 0; seg < 40; seg++) begin
            rmode = int'($urandom_range(0, 3));
            for (int c = 0; c < 60; c++) begin
                reset = ($urandom_range(0, 299) == 0);
                if (req_left > 0) begin
                    req_left--;
                    if (req_left == 0) req_val = '0;
                end else if ($urandom_range(0, 59) == 0) begin
                    req_left = int'($urandom_range(1, 6));
                    req_val = NREQ'($urandom_range(1, 7));
                end
                req = req_val;
                case (rmode)
                    0:       domain_ready = 2'b11;
                    1:       domain_ready = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
                    2:       domain_ready = {1'($urandom_range(0, 1)), 1'b0};
                    default: domain_ready = 2'b01;
                endcase
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
